sram_mem_controller: RTL and testbench

- Sits directly downstream of the MEM stage and replaces the on-chip data memory with an external 16-bit asynchronous SRAM.
- Accepts one 32-bit load or store per request and performs it as two sequential 16-bit SRAM accesses: low half first, then high half.
- Holds `ready` low while busy; the pipeline uses `~ready` as its global freeze.

---
 rtl/sram_mem_controller.sv | 156 +++++++++++++++
 tb/tb_sram_mem_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// sram_mem_controller
//   Replaces on-chip data memory with an external 16-bit asynchronous SRAM.
//   Each 32-bit load/store becomes two 16-bit SRAM accesses (low half, then
//   high half). Each half is held for WAIT_CYCLES+1 cycles.
//
//   Handshake: the pipeline holds wr_en/rd_en, address and write_data stable
//   until it samples ready=1. ready is high in IDLE with no request pending
//   and in the single DONE cycle. The pipeline freezes on ~ready.
//
//   Optional feature: define SRAM_ADDR_CHECK_EN to reject requests outside
//   [BASE_ADDR, BASE_ADDR + 2^19). A rejected request goes straight to DONE
//   with an addr_err pulse and no SRAM activity. Without the macro addr_err
//   is tied low and addresses wrap modulo 2^19 bytes.
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   wr_en, rd_en      store / load request (store wins if both are set)
//   address           byte address, word aligned
//   write_data        store data
//   read_data         load result, held until the next load completes
//   ready             no operation pending, or operation completing now
//   addr_err          address-range error pulse
//   sram_addr         SRAM half-word address {word, half}
//   sram_dq_out       data driven to SRAM
//   sram_dq_oe        DQ pad output enable
//   sram_dq_in        data returned from SRAM
//   sram_we_n         SRAM write strobe, active low
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        addr_err,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            op_wr;
  logic [16:0]     word_q;
  logic [31:0]     wdata_q;
  logic [15:0]     lo_q;
  logic [31:0]     off;
  logic            req;
  logic            last;
  logic            range_bad;
  logic            active;
  logic            half;
  logic            unused_bits;

  assign off  = address - BASE_ADDR;
  assign req  = wr_en | rd_en;
  // Final cycle of a half-access.
  assign last = (cnt == CW'(WAIT_CYCLES));

`ifdef SRAM_ADDR_CHECK_EN
  logic err_q;
  assign range_bad = (address < BASE_ADDR) || (off[31:19] != 13'd0);
  assign addr_err  = (state == DONE) && err_q;
`else
  assign range_bad = 1'b0;
  assign addr_err  = 1'b0;
`endif

  // Offset bits outside the SRAM word index are intentionally dropped.
  assign unused_bits = ^{off[31:19], off[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      read_data <= '0;
`ifdef SRAM_ADDR_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req) begin
            op_wr   <= wr_en;
            word_q  <= off[18:2];
            wdata_q <= write_data;
            cnt     <= '0;
`ifdef SRAM_ADDR_CHECK_EN
            err_q   <= range_bad;
`endif
            // A rejected load returns zero.
            if (range_bad && !wr_en) read_data <= '0;
          end
        end
        LO: begin
          if (last) begin
            cnt <= '0;
            if (!op_wr) lo_q <= sram_dq_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HI: begin
          if (last) begin
            cnt <= '0;
            if (!op_wr) read_data <= {sram_dq_in, lo_q};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
`ifdef SRAM_ADDR_CHECK_EN
          err_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = range_bad ? DONE : LO;
      LO:   if (last) state_nx = HI;
      HI:   if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign active      = (state == LO) || (state == HI);
  assign half        = (state == HI);
  assign ready       = (state == IDLE) ? ~req : (state == DONE);
  assign sram_addr   = {word_q, half};
  assign sram_dq_oe  = active & op_wr;
  assign sram_we_n   = ~(active & op_wr);
  assign sram_dq_out = sram_dq_oe ? (half ? wdata_q[31:16] : wdata_q[15:0]) : 16'h0000;

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller
//   Directed bench for sram_mem_controller. A behavioural SRAM supplies
//   sram_dq_in; a transaction-level model tracks the expected timeline of
//   each request and a reference memory, and a compare process checks every
//   output on every falling edge. Literal expectations pin the model.
module tb_sram_mem_controller;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int          W    = 1;
  localparam int          L    = W + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        addr_err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sram_mem_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .addr_err(addr_err), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  // ---------------- behavioural SRAM ----------------
  logic [15:0] sram_mem [0:262143];
  logic [15:0] ref_mem  [0:262143];
  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  bit          busy = 0;
  int          t = 0;
  bit          m_wr, m_bad;
  logic [16:0] m_word;
  logic [31:0] m_wd;
  logic [31:0] exp_rd = '0;
  int          done_t;

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef SRAM_ADDR_CHECK_EN
    return (a < BASE) || ((a - BASE) >= 32'h0008_0000);
`else
    return (a == a) ? 1'b0 : 1'b1;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (!busy) begin
        chk("idle_ready", {31'd0, ready}, {31'd0, ~(wr_en | rd_en)});
        chk("idle_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("idle_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("idle_err", {31'd0, addr_err}, 32'd0);
        chk("idle_rdata", read_data, exp_rd);
        if (wr_en | rd_en) begin
          logic [31:0] off;
          off    = address - BASE;
          busy   = 1;
          t      = 0;
          m_wr   = wr_en;
          m_word = off[18:2];
          m_wd   = write_data;
          m_bad  = out_of_range(address);
        end
      end else begin
        t++;
        done_t = m_bad ? 1 : 2 * L + 1;
        if (t == done_t) begin
          if (m_wr && !m_bad) begin
            ref_mem[{m_word, 1'b0}] = m_wd[15:0];
            ref_mem[{m_word, 1'b1}] = m_wd[31:16];
          end else if (!m_wr) begin
            exp_rd = m_bad ? 32'd0 : {ref_mem[{m_word, 1'b1}], ref_mem[{m_word, 1'b0}]};
          end
          chk("done_ready", {31'd0, ready}, 32'd1);
          chk("done_we_n", {31'd0, sram_we_n}, 32'd1);
          chk("done_oe", {31'd0, sram_dq_oe}, 32'd0);
          chk("done_err", {31'd0, addr_err}, {31'd0, m_bad});
          chk("done_rdata", read_data, exp_rd);
          busy = 0;
        end else begin
          bit hf;
          hf = (t > L);
          chk("busy_ready", {31'd0, ready}, 32'd0);
          chk("busy_addr", {14'd0, sram_addr}, {14'd0, m_word, hf});
          chk("busy_we_n", {31'd0, sram_we_n}, {31'd0, ~m_wr});
          chk("busy_oe", {31'd0, sram_dq_oe}, {31'd0, m_wr});
          if (m_wr) chk("busy_dq", {16'd0, sram_dq_out}, {16'd0, hf ? m_wd[31:16] : m_wd[15:0]});
          chk("busy_err", {31'd0, addr_err}, 32'd0);
          chk("busy_rdata", read_data, exp_rd);
        end
      end
    end
  end

  // Reset during cycle cyc of a store: halves whose strobe saw a clock edge landed.
  task automatic model_abort(input int cyc);
    if (busy && m_wr) begin
      if (cyc >= 2)     ref_mem[{m_word, 1'b0}] = m_wd[15:0];
      if (cyc >= L + 2) ref_mem[{m_word, 1'b1}] = m_wd[31:16];
    end
    busy   = 0;
    exp_rd = '0;
  endtask

  // ---------------- driver ----------------
  logic [17:0] cap_addr [0:15];
  logic [15:0] cap_dq   [0:15];
  logic        cap_we   [0:15];
  logic        cap_oe   [0:15];
  logic        cap_rdy  [0:15];
  logic        cap_err  [0:15];
  logic        rdy_imm;

  task automatic do_op(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, output int lat);
    bit found;
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    #1 rdy_imm = ready;
    lat = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 16) begin
        cap_addr[i] = sram_addr; cap_dq[i] = sram_dq_out; cap_we[i] = sram_we_n;
        cap_oe[i] = sram_dq_oe; cap_rdy[i] = ready; cap_err[i] = addr_err;
      end
      if (ready) begin found = 1; break; end
      lat++;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL op_timeout: got no ready expected ready within 40 cycles");
    end
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
  endtask

  logic [17:0] st_addr [1:4] = '{18'd0, 18'd0, 18'd1, 18'd1};
  logic [15:0] st_dq   [1:4] = '{16'h5678, 16'h5678, 16'h1234, 16'h1234};

  initial begin
    int lat;
    for (int i = 0; i < 262144; i++) begin
      sram_mem[i] = 16'(i) ^ 16'h5A5A;
      ref_mem[i]  = 16'(i) ^ 16'h5A5A;
    end
    sram_mem[2] = 16'hBABE; ref_mem[2] = 16'hBABE;
    sram_mem[3] = 16'hCAFE; ref_mem[3] = 16'hCAFE;

    // reset values
    #1;
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_dq", {16'd0, sram_dq_out}, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // store 0x12345678 to 0x400
    do_op(1, 0, 32'h400, 32'h1234_5678, lat);
    chk("st_lat", 32'(lat), 32'd5);
    for (int i = 1; i <= 4; i++) begin
      chk("st_addr", {14'd0, cap_addr[i]}, {14'd0, st_addr[i]});
      chk("st_dq", {16'd0, cap_dq[i]}, {16'd0, st_dq[i]});
      chk("st_we_n", {31'd0, cap_we[i]}, 32'd0);
    end
    chk("st_done_we_n", {31'd0, cap_we[5]}, 32'd1);
    chk("st_mem_lo", {16'd0, sram_mem[0]}, 32'h5678);
    chk("st_mem_hi", {16'd0, sram_mem[1]}, 32'h1234);

    // load 0x404
    do_op(0, 1, 32'h404, 32'h0, lat);
    chk("ld_lat", 32'(lat), 32'd5);
    chk("ld_rdata", read_data, 32'hCAFE_BABE);
    for (int i = 0; i <= 5; i++) begin
      chk("ld_oe", {31'd0, cap_oe[i]}, 32'd0);
      chk("ld_ready", {31'd0, cap_rdy[i]}, (i == 5) ? 32'd1 : 32'd0);
    end

    // idle for 10 cycles, then ready drops combinationally on rd_en
    repeat (10) @(posedge clk);
    do_op(0, 1, 32'h400, 32'h0, lat);
    chk("rd_ready_imm", {31'd0, rdy_imm}, 32'd0);
    chk("rd400_rdata", read_data, 32'h1234_5678);

    // both enables: write wins, read_data untouched
    do_op(1, 1, 32'h408, 32'hA5A5_5A5A, lat);
    chk("both_rdata", read_data, 32'h1234_5678);
    chk("both_mem_lo", {16'd0, sram_mem[4]}, 32'h5A5A);
    chk("both_mem_hi", {16'd0, sram_mem[5]}, 32'hA5A5);

    // reset during cycle 3 of a store
    @(posedge clk); #1;
    wr_en = 1; address = 32'h400; write_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    model_abort(3);
    #1;
    chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("abort_rdata", read_data, 32'd0);
    wr_en = 0;
    @(posedge clk); #1 rst = 0;
    do_op(0, 1, 32'h400, 32'h0, lat);
    chk("abort_ld_lat", 32'(lat), 32'd5);
    chk("abort_ld_rdata", read_data, 32'h1234_BEEF);

    // wrap / out-of-range high: model decides per build
    do_op(0, 1, 32'h0008_0404, 32'h0, lat);

    // out-of-range low
    do_op(0, 1, 32'h3FC, 32'h0, lat);
`ifdef SRAM_ADDR_CHECK_EN
    chk("oor_lat", 32'(lat), 32'd1);
    chk("oor_rdata", read_data, 32'd0);
    chk("oor_err", {31'd0, cap_err[1]}, 32'd1);
    chk("oor_we_n", {31'd0, cap_we[0] & cap_we[1]}, 32'd1);
`else
    chk("wrap_lat", 32'(lat), 32'd5);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
